// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_pkg
//  Purpose  : Shared bus address map, IO status bit positions and FSM states
//             for the MMIO polling bus master.
//  Revision : 1.0 - initial release
// ============================================================================
package mmio_pkg;

    // IO register byte addresses (bit7 set selects the IO space)
    localparam logic [7:0] STATUS_ADDR = 8'h80;
    localparam logic [7:0] SWITCH_ADDR = 8'h84;
    localparam logic [7:0] LED_ADDR    = 8'h88;

    // Pending-button bits inside the status register
    localparam int BTNL_BIT = 1;
    localparam int BTNR_BIT = 0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        POLL  = 3'd2,
        RDSW  = 3'd3,
        WRLED = 3'd4,
        WRLOG = 3'd5,
        CLR   = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/poll_timer.sv
`default_nettype none
// ============================================================================
//  Module   : poll_timer
//  Purpose  : Loadable down-counter; after a load, expire is high during the
//             POLL_DIV-th cycle so the caller spends exactly POLL_DIV cycles
//             waiting.
//  Revision : 1.0 - initial release
// ============================================================================
module poll_timer #(
    parameter int POLL_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expire
);

    localparam int            CW       = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(POLL_DIV - 1);

    logic [CW-1:0] r_count;
    logic          r_run;

    // Count down from POLL_DIV-1 after a load; stop once the zero cycle is seen
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_run   <= 1'b0;
        end else if (load) begin
            r_count <= LOAD_VAL;
            r_run   <= 1'b1;
        end else if (expire) begin
            r_run   <= 1'b0;
        end else if (r_run) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign expire = r_run && (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mmio_poll_master.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_poll_master
//  Purpose  : Bring-up bus initiator. Polls the IO status register; on btnL
//             reads the switches, writes the byte sum to the LEDs and logs it
//             into a circular buffer in data memory; on btnR clears the LEDs.
//  Revision : 1.0 - initial release
// ============================================================================
module mmio_poll_master #(
    parameter int         POLL_DIV  = 16,
    parameter logic [7:0] LOG_BASE  = 8'h40,
    parameter int         LOG_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [7:0]  addr,
    output logic        write,
    output logic [31:0] writeData,
    input  logic [31:0] readData,
    output logic        busy,
    output logic [3:0]  log_count
);

    import mmio_pkg::*;

    localparam int PW = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;

    state_t          r_state;
    state_t          w_next;
    logic            w_load;
    logic            w_expire;
    logic [8:0]      w_sum;
    logic [8:0]      r_sum;
    logic [15:0]     r_sw;
    logic [PW-1:0]   r_ptr;
    logic [3:0]      r_log_count;
    logic [7:0]      w_log_addr;
    logic [7:0]      w_addr;
    logic            w_write;
    logic [31:0]     w_wdata;
    logic            w_unused_rd;

    // Only the low half of readData carries information for this master
    assign w_unused_rd = &{1'b0, readData[31:16]};

    // Byte sum of the switch word, widened so the carry is kept
    assign w_sum      = {1'b0, readData[15:8]} + {1'b0, readData[7:0]};
    assign w_log_addr = LOG_BASE + 8'({r_ptr, 2'b00});

    // Restart the poll interval on every entry into WAIT
    assign w_load = (w_next == WAIT) && (r_state != WAIT);

    poll_timer #(
        .POLL_DIV (POLL_DIV)
    ) u_poll_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (w_load),
        .expire (w_expire)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state decision; readData is looked at while the read address is on the bus
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (en) w_next = WAIT;
            WAIT:    if (w_expire) w_next = en ? POLL : IDLE;
            POLL: begin
                if (readData[BTNL_BIT])      w_next = RDSW;
                else if (readData[BTNR_BIT]) w_next = CLR;
                else                         w_next = WAIT;
            end
            RDSW:    w_next = WRLED;
            WRLED:   w_next = WRLOG;
            WRLOG:   w_next = WAIT;
            CLR:     w_next = WAIT;
            default: w_next = IDLE;
        endcase
    end

    // Bus values for the state being entered, so they are registered and stable all cycle
    always_comb begin
        w_addr  = 8'h00;
        w_write = 1'b0;
        w_wdata = 32'h0;
        case (w_next)
            POLL:  w_addr = STATUS_ADDR;
            RDSW:  w_addr = SWITCH_ADDR;
            WRLED: begin
                // Entered only from RDSW, so readData still shows the switches
                w_addr  = LED_ADDR;
                w_write = 1'b1;
                w_wdata = {23'b0, w_sum};
            end
            WRLOG: begin
                w_addr  = w_log_addr;
                w_write = 1'b1;
                w_wdata = {7'b0, r_sw, r_sum};
            end
            CLR: begin
                w_addr  = LED_ADDR;
                w_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Registered bus outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr      <= 8'h00;
            write     <= 1'b0;
            writeData <= 32'h0;
        end else begin
            addr      <= w_addr;
            write     <= w_write;
            writeData <= w_wdata;
        end
    end

    // Switch capture, log pointer and saturating log counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sum       <= 9'h0;
            r_sw        <= 16'h0;
            r_ptr       <= '0;
            r_log_count <= 4'h0;
        end else begin
            if (r_state == RDSW) begin
                r_sum <= w_sum;
                r_sw  <= readData[15:0];
            end
            if (r_state == WRLOG) begin
                r_ptr <= (LOG_DEPTH > 1) ? r_ptr + 1'b1 : '0;
                if (r_log_count != 4'hF) r_log_count <= r_log_count + 4'h1;
            end
        end
    end

    assign busy      = (r_state != IDLE);
    assign log_count = r_log_count;

endmodule
`default_nettype wire

// File: tb/tb_mmio_poll_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mmio_poll_master
//  Purpose  : Self-checking bench for mmio_poll_master with a behavioural
//             bus/IO model and a log-pointer reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mmio_poll_master;

    localparam int         POLL_DIV  = 5;
    localparam logic [7:0] LOG_BASE  = 8'h40;
    localparam int         LOG_DEPTH = 8;
    localparam logic [7:0] A_STATUS  = 8'h80;
    localparam logic [7:0] A_SWITCH  = 8'h84;
    localparam logic [7:0] A_LED     = 8'h88;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        en    = 1'b0;
    logic [7:0]  addr;
    logic        write;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        busy;
    logic [3:0]  log_count;

    logic [1:0]  status = 2'b00;
    logic [15:0] sw     = 16'h0;
    logic [31:0] noise  = 32'h0;

    int errors = 0;
    int checks = 0;
    int m_ptr   = 0;
    int m_count = 0;

    mmio_poll_master #(
        .POLL_DIV  (POLL_DIV),
        .LOG_BASE  (LOG_BASE),
        .LOG_DEPTH (LOG_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .addr      (addr),
        .write     (write),
        .writeData (writeData),
        .readData  (readData),
        .busy      (busy),
        .log_count (log_count)
    );

    always #5 clk = ~clk;

    // IO / memory model: combinational read data with junk in unused bits
    always_comb begin
        case (addr)
            A_STATUS: readData = {noise[31:2], status};
            A_SWITCH: readData = {noise[31:16], sw};
            default:  readData = noise;
        endcase
    end

    // ---------------- reference model ----------------
    function automatic logic [8:0] exp_sum(input logic [15:0] s);
        return 9'(int'(s[15:8]) + int'(s[7:0]));
    endfunction

    function automatic logic [7:0] exp_log_addr();
        return LOG_BASE + 8'(4 * m_ptr);
    endfunction

    task automatic model_log();
        m_ptr   = (m_ptr + 1) % LOG_DEPTH;
        m_count = (m_count < 15) ? m_count + 1 : 15;
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_count = 0;
    endtask

    // Advance to the next negedge where a status read is on the bus
    task automatic wait_poll(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3 * POLL_DIV + 8; i++) begin
            @(negedge clk);
            if (addr == A_STATUS && !write) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; en = 1'b0; status = 2'b00;
        repeat (3) @(negedge clk);
        checks++; if (addr !== 8'h00)      begin errors++; $display("FAIL reset_addr: got %h want 00", addr); end
        checks++; if (write !== 1'b0)      begin errors++; $display("FAIL reset_write: got %b want 0", write); end
        checks++; if (writeData !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", writeData); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (log_count !== 4'h0)  begin errors++; $display("FAIL reset_log_count: got %0d want 0", log_count); end
        model_reset();
    endtask

    task automatic test_idle_poll();
        int prev = -1, first = -1, n_polls = 0, n_writes = 0, n_other = 0;
        noise = $urandom;
        reset = 1'b0; en = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (write) n_writes++;
            if (addr == A_STATUS) begin
                if (first < 0) first = c;
                if (prev >= 0) begin
                    checks++;
                    if (c - prev != POLL_DIV + 1) begin
                        errors++; $display("FAIL poll_spacing: got %0d want %0d", c - prev, POLL_DIV + 1);
                    end
                end
                prev = c; n_polls++;
            end else if (addr !== 8'h00) n_other++;
        end
        checks++; if (first < POLL_DIV || first > POLL_DIV + 1) begin errors++; $display("FAIL first_poll: got cycle %0d want %0d..%0d", first, POLL_DIV, POLL_DIV + 1); end
        checks++; if (n_writes != 0) begin errors++; $display("FAIL idle_writes: got %0d want 0", n_writes); end
        checks++; if (n_other != 0)  begin errors++; $display("FAIL idle_other_addr: got %0d want 0", n_other); end
        checks++; if (n_polls < 100 / (POLL_DIV + 1) - 1) begin errors++; $display("FAIL idle_poll_count: got %0d want >=%0d", n_polls, 100 / (POLL_DIV + 1) - 1); end
    endtask

    task automatic test_btnl();
        bit ok;
        wait_poll(ok);
        checks++; if (!ok) begin errors++; $display("FAIL btnl_poll: got timeout want status read"); end
        status = 2'b10; sw = 16'hFF01; noise = $urandom;
        @(negedge clk);
        checks++; if ({addr, write} !== {A_SWITCH, 1'b0}) begin errors++; $display("FAIL btnl_rdsw: got %h/%b want %h/0", addr, write, A_SWITCH); end
        @(negedge clk);
        checks++; if ({addr, write, writeData} !== {A_LED, 1'b1, 32'h100}) begin errors++; $display("FAIL btnl_led: got %h/%b/%h want 88/1/00000100", addr, write, writeData); end
        status = 2'b00;
        @(negedge clk);
        checks++; if ({addr, write, writeData} !== {8'h40, 1'b1, 7'b0, 16'hFF01, 9'h100}) begin errors++; $display("FAIL btnl_log: got %h/%b/%h want 40/1/%h", addr, write, writeData, {7'b0, 16'hFF01, 9'h100}); end
        model_log();
        @(negedge clk);
        checks++; if (log_count !== 4'(m_count)) begin errors++; $display("FAIL btnl_log_count: got %0d want %0d", log_count, m_count); end
        checks++; if (write !== 1'b0) begin errors++; $display("FAIL btnl_after_write: got %b want 0", write); end
    endtask

    task automatic test_both();
        bit ok;
        logic [15:0] s;
        wait_poll(ok);
        checks++; if (!ok) begin errors++; $display("FAIL both_poll: got timeout want status read"); end
        s = 16'($urandom) | 16'h0001;
        status = 2'b11; sw = s;
        @(negedge clk);
        checks++; if ({addr, write} !== {A_SWITCH, 1'b0}) begin errors++; $display("FAIL both_rdsw: got %h/%b want %h/0", addr, write, A_SWITCH); end
        @(negedge clk);
        checks++; if ({addr, write, writeData} !== {A_LED, 1'b1, 23'b0, exp_sum(s)}) begin errors++; $display("FAIL both_led: got %h/%b/%h want 88/1/%h", addr, write, writeData, {23'b0, exp_sum(s)}); end
        status = 2'b00;
        @(negedge clk);
        checks++; if ({addr, write, writeData} !== {exp_log_addr(), 1'b1, 7'b0, s, exp_sum(s)}) begin errors++; $display("FAIL both_log: got %h/%b/%h want %h/1/%h", addr, write, writeData, exp_log_addr(), {7'b0, s, exp_sum(s)}); end
        model_log();
    endtask

    task automatic test_btnr();
        bit ok;
        int gap = 0;
        wait_poll(ok);
        checks++; if (!ok) begin errors++; $display("FAIL btnr_poll: got timeout want status read"); end
        status = 2'b01; sw = 16'($urandom);
        @(negedge clk);
        checks++; if ({addr, write, writeData} !== {A_LED, 1'b1, 32'h0}) begin errors++; $display("FAIL btnr_clear: got %h/%b/%h want 88/1/0", addr, write, writeData); end
        status = 2'b00;
        for (int c = 1; c <= 3 * POLL_DIV; c++) begin
            @(negedge clk);
            checks++; if (write !== 1'b0) begin errors++; $display("FAIL btnr_extra_write: got addr %h want no write", addr); end
            if (addr == A_STATUS) begin gap = c; break; end
        end
        checks++; if (gap != POLL_DIV + 1) begin errors++; $display("FAIL btnr_next_poll: got %0d want %0d", gap, POLL_DIV + 1); end
        checks++; if (log_count !== 4'(m_count)) begin errors++; $display("FAIL btnr_log_count: got %0d want %0d", log_count, m_count); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 10; k++) begin
            bit ok;
            logic [1:0]  st;
            logic [15:0] s;
            wait_poll(ok);
            checks++; if (!ok) begin errors++; $display("FAIL rnd_poll: got timeout want status read"); end
            st = 2'($urandom_range(0, 3)); s = 16'($urandom); noise = $urandom;
            status = st; sw = s;
            @(negedge clk);
            if (st[1]) begin
                checks++; if ({addr, write} !== {A_SWITCH, 1'b0}) begin errors++; $display("FAIL rnd_rdsw: got %h/%b want %h/0", addr, write, A_SWITCH); end
                @(negedge clk);
                checks++; if ({addr, write, writeData} !== {A_LED, 1'b1, 23'b0, exp_sum(s)}) begin errors++; $display("FAIL rnd_led: got %h/%b/%h want 88/1/%h", addr, write, writeData, {23'b0, exp_sum(s)}); end
                status = 2'b00;
                @(negedge clk);
                checks++; if ({addr, write, writeData} !== {exp_log_addr(), 1'b1, 7'b0, s, exp_sum(s)}) begin errors++; $display("FAIL rnd_log: got %h/%b/%h want %h/1/%h", addr, write, writeData, exp_log_addr(), {7'b0, s, exp_sum(s)}); end
                model_log();
            end else if (st[0]) begin
                checks++; if ({addr, write, writeData} !== {A_LED, 1'b1, 32'h0}) begin errors++; $display("FAIL rnd_clear: got %h/%b/%h want 88/1/0", addr, write, writeData); end
            end else begin
                checks++; if ({addr, write} !== {8'h00, 1'b0}) begin errors++; $display("FAIL rnd_idle: got %h/%b want 00/0", addr, write); end
            end
            status = 2'b00;
            @(negedge clk);
            checks++; if (log_count !== 4'(m_count)) begin errors++; $display("FAIL rnd_log_count: got %0d want %0d", log_count, m_count); end
        end
    endtask

    task automatic test_log_wrap();
        status = 2'b00;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 9; k++) begin
            bit ok;
            logic [15:0] s;
            wait_poll(ok);
            checks++; if (!ok) begin errors++; $display("FAIL wrap_poll: got timeout want status read"); end
            s = 16'($urandom);
            status = 2'b10; sw = s;
            repeat (2) @(negedge clk);
            status = 2'b00;
            @(negedge clk);
            checks++; if ({addr, write, writeData} !== {exp_log_addr(), 1'b1, 7'b0, s, exp_sum(s)}) begin errors++; $display("FAIL wrap_log%0d: got %h/%b/%h want %h/1/%h", k, addr, write, writeData, exp_log_addr(), {7'b0, s, exp_sum(s)}); end
            model_log();
        end
        @(negedge clk);
        checks++; if (log_count !== 4'(m_count)) begin errors++; $display("FAIL wrap_log_count: got %0d want %0d", log_count, m_count); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int first = -1, wr = 0;
        wait_poll(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rmid_poll: got timeout want status read"); end
        status = 2'b10; sw = 16'($urandom) | 16'h0100;
        repeat (2) @(negedge clk);
        checks++; if ({addr, write} !== {A_LED, 1'b1}) begin errors++; $display("FAIL rmid_in_wrled: got %h/%b want 88/1", addr, write); end
        #2 reset = 1'b1; status = 2'b00;
        #1;
        checks++; if ({addr, write, writeData, busy, log_count} !== 46'h0) begin errors++; $display("FAIL rmid_clear: got %h/%b/%h/%b/%0d want all 0", addr, write, writeData, busy, log_count); end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int c = 1; c <= 3 * POLL_DIV + 8; c++) begin
            @(negedge clk);
            if (write) wr++;
            if (addr != 8'h00) begin first = c; break; end
        end
        checks++; if (addr !== A_STATUS) begin errors++; $display("FAIL rmid_first_addr: got %h want %h", addr, A_STATUS); end
        checks++; if (first < POLL_DIV || first > POLL_DIV + 1) begin errors++; $display("FAIL rmid_first_cycle: got %0d want %0d..%0d", first, POLL_DIV, POLL_DIV + 1); end
        checks++; if (wr != 0 || log_count !== 4'h0) begin errors++; $display("FAIL rmid_reissue: got %0d writes count %0d want 0/0", wr, log_count); end
    endtask

    task automatic test_en_drop();
        bit ok;
        logic [15:0] s;
        int polls = 0, idle_at = -1;
        wait_poll(ok);
        checks++; if (!ok) begin errors++; $display("FAIL endrop_poll: got timeout want status read"); end
        s = 16'($urandom);
        status = 2'b10; sw = s;
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        checks++; if ({addr, write, writeData} !== {A_LED, 1'b1, 23'b0, exp_sum(s)}) begin errors++; $display("FAIL endrop_led: got %h/%b/%h want 88/1/%h", addr, write, writeData, {23'b0, exp_sum(s)}); end
        status = 2'b00;
        @(negedge clk);
        checks++; if ({addr, write, writeData} !== {exp_log_addr(), 1'b1, 7'b0, s, exp_sum(s)}) begin errors++; $display("FAIL endrop_log: got %h/%b/%h want %h/1/%h", addr, write, writeData, exp_log_addr(), {7'b0, s, exp_sum(s)}); end
        model_log();
        for (int c = 1; c <= POLL_DIV + 4; c++) begin
            @(negedge clk);
            if (addr == A_STATUS) polls++;
            if (!busy && idle_at < 0) idle_at = c;
        end
        checks++; if (idle_at < 1 || idle_at > POLL_DIV + 1) begin errors++; $display("FAIL endrop_idle: got cycle %0d want 1..%0d", idle_at, POLL_DIV + 1); end
        checks++; if (polls != 0) begin errors++; $display("FAIL endrop_polls: got %0d want 0", polls); end
        checks++; if ({addr, write, log_count} !== {8'h00, 1'b0, 4'(m_count)}) begin errors++; $display("FAIL endrop_park: got %h/%b/%0d want 00/0/%0d", addr, write, log_count, m_count); end
    endtask

    initial begin
        test_reset();
        test_idle_poll();
        test_btnl();
        test_both();
        test_btnr();
        test_random();
        test_log_wrap();
        test_reset_mid();
        test_en_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish before 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mmio_poll_master.md
Name: mmio_poll_master

Overview:
- Hardware bus initiator that drives the same 8-bit memory-mapped data bus the CPU uses: addr, write, writeData out; readData in.
- Acts as the master side of the dMem/IO address decoder:
  - polls the IO status register;
  - on a button event, reads the switch register, adds the two switch bytes, and writes the sum to the LED register;
  - logs each result into a circular buffer in data memory.
- Used for board bring-up and self-test in place of the MIPS core.

Parameters:
- POLL_DIV, 16, clock cycles waited in WAIT between status polls (must be ≥1).
- LOG_BASE, 8'h40, first data-memory byte address of the result log (addr[7] must be 0).
- LOG_DEPTH, 8, number of 32-bit log entries (power of 2, ≤16).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  1 = run; 0 = finish the current transaction, then park in IDLE.
- addr  out  8  bus byte address; bit7 = 1 selects IO, 0 selects dmem.
- write  out  1  write strobe, one cycle per store.
- writeData  out  32  store data.
- readData  in  32  load data, combinational from addr in the same cycle.
- busy  out  1  high in any state other than IDLE.
- log_count  out  4  entries written since reset, saturates at 15.

Behaviour:
- Address map (fixed constants):
  - STATUS = 8'h80: readData[1] = btnL pending, [0] = btnR pending.
  - SWITCH = 8'h84: readData[15:0] = switches.
  - LED = 8'h88: low 12 bits are written.
- Reset values: addr = 0, write = 0, writeData = 0, busy = 0, log_count = 0. Internal: wait counter 0, log pointer 0, FSM in IDLE.
- Outputs are registered. Each FSM state lasts exactly one cycle except WAIT. readData is sampled at the clock edge that leaves the state.
- FSM states and transitions:
  - IDLE: addr = 0, write = 0. Go to WAIT when en = 1.
  - WAIT: count POLL_DIV cycles. If en = 0 → IDLE. Otherwise → POLL.
  - POLL: addr = STATUS.
    - If readData[1] = 1 → RDSW (btnL wins when both bits are set).
    - Else if readData[0] = 1 → CLR.
    - Else → WAIT.
  - RDSW: addr = SWITCH. Latch sum = {1'b0, readData[15:8]} + {1'b0, readData[7:0]} (9 bits, no overflow loss). → WRLED.
  - WRLED: addr = LED, write = 1, writeData = {23'b0, sum}. → WRLOG.
  - WRLOG: addr = LOG_BASE + 4*ptr, write = 1, writeData = {7'b0, sw[15:0], sum}. Then:
    - ptr ← (ptr + 1) mod LOG_DEPTH (wraps; oldest entry is overwritten);
    - log_count ← min(log_count + 1, 15).
    - → WAIT.
  - CLR: addr = LED, write = 1, writeData = 0. ptr is unchanged. → WAIT.
- write is never asserted in IDLE, WAIT, POLL or RDSW.
- addr is held stable for the whole cycle of each state.
- en deasserted mid-sequence (RDSW/WRLED/WRLOG/CLR): the sequence completes, then the FSM parks in IDLE on the next WAIT decision.
- Reset asserted mid-sequence: all state clears immediately. No partial write is reissued after reset.
- Latency: status hit in POLL → LED write 2 cycles later → log write 3 cycles later.

Decomposition:
- Package mmio_pkg:
  - address constants STATUS_ADDR, SWITCH_ADDR, LED_ADDR;
  - bit indices BTNL_BIT = 1, BTNR_BIT = 0;
  - typedef enum logic[2:0] state_t {IDLE, WAIT, POLL, RDSW, WRLED, WRLOG, CLR}.
- One sub-module: poll_timer, a loadable down-counter that pulses expire after POLL_DIV cycles.

Test Plan:
- Reset then en = 1, status = 0 for 100 cycles → only reads at 8'h80, spaced POLL_DIV + 1 cycles apart; write stays 0.
- Status = 2'b10, switches = 16'hFF01 → LED write 32'h100 at 8'h88, then log write 8'h40 = {7'b0, 16'hFF01, 9'h100}; log_count = 1.
- Status = 2'b11 → btnL path taken (sum written), no clear issued.
- Status = 2'b01 → write 0 to 8'h88; no log write; log_count unchanged.
- Nine btnL events with LOG_DEPTH = 8 → log addresses 8'h40, 8'h44 … 8'h5C, then 8'h40 again; log_count = 9.
- Reset pulse asserted during WRLED → all outputs 0 immediately. After release with en = 1, the first bus access is a STATUS read after POLL_DIV cycles.
